// File: rtl/xvc_mm_axil_bridge.sv
// Bridge from the XVC core's simple register port to a single-outstanding AXI4-Lite master.
// Each WRITE or READ command becomes one AXI-Lite transaction. Completion is reported by a
// one-cycle wdone or rvalid pulse. err records any non-OKAY response since reset.
module xvc_mm_axil_bridge #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,

  // XVC core side
  input  logic [11:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [1:0]                opcode,
  output logic [31:0]               rdata,
  output logic                      rvalid,
  output logic                      wdone,
  output logic                      busy,

  // AXI-Lite write address
  output logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,

  // AXI-Lite write data
  output logic [31:0]               m_axil_wdata,
  output logic [3:0]                m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,

  // AXI-Lite write response
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,

  // AXI-Lite read address
  output logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]                m_axil_arprot,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,

  // AXI-Lite read data
  input  logic [31:0]               m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready,

  output logic                      err
);

  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData
  } state_e;

  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;

  // Sum wraps naturally at AXI_ADDR_WIDTH bits.
  assign axi_addr = BASE_ADDR + AXI_ADDR_WIDTH'(addr);

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;

  // Fixed AXI attributes: unprivileged, secure, data access; full-word writes only.
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = 4'hF;

  // Transaction sequencer; every handshake and status output is a flop driven from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      busy           <= 1'b0;
      wdone          <= 1'b0;
      rvalid         <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      // Completion pulses last a single cycle.
      wdone  <= 1'b0;
      rvalid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (opcode == OpWrite) begin
            m_axil_awaddr  <= axi_addr;
            m_axil_wdata   <= wdata;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            busy           <= 1'b1;
            state_q        <= StWr;
          end else if (opcode == OpRead) begin
            m_axil_araddr  <= axi_addr;
            m_axil_arvalid <= 1'b1;
            busy           <= 1'b1;
            state_q        <= StRdAddr;
          end
        end

        StWr: begin
          // AW and W retire independently; a dropped valid means that channel is done.
          if (aw_hs) m_axil_awvalid <= 1'b0;
          if (w_hs)  m_axil_wvalid  <= 1'b0;
          if ((aw_hs || !m_axil_awvalid) && (w_hs || !m_axil_wvalid)) begin
            m_axil_bready <= 1'b1;
            state_q       <= StWrResp;
          end
        end

        StWrResp: begin
          // bready high: waiting for B. bready low: response taken, report next.
          if (m_axil_bready) begin
            if (m_axil_bvalid) begin
              m_axil_bready <= 1'b0;
              if (m_axil_bresp != 2'b00) err <= 1'b1;
            end
          end else begin
            wdone   <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        StRdAddr: begin
          if (ar_hs) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state_q        <= StRdData;
          end
        end

        StRdData: begin
          // Same two-phase scheme as StWrResp, keyed on rready.
          if (m_axil_rready) begin
            if (m_axil_rvalid) begin
              m_axil_rready <= 1'b0;
              rdata         <= m_axil_rdata;
              if (m_axil_rresp != 2'b00) err <= 1'b1;
            end
          end else begin
            rvalid  <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xvc_mm_axil_bridge.sv
// Scoreboard bench for xvc_mm_axil_bridge: stimulus pushes expected AXI requests and
// completion responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_xvc_mm_axil_bridge;

  localparam logic [31:0] Base    = 32'h0000_4000;
  localparam logic [1:0]  OpWait  = 2'd0;
  localparam logic [1:0]  OpWrite = 2'd1;
  localparam logic [1:0]  OpRead  = 2'd2;
  localparam logic [1:0]  OpRsvd  = 2'd3;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          err;
    int          busy;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] addr;
  logic [31:0] wdata;
  logic [1:0]  opcode;
  logic [31:0] rdata;
  logic        rvalid, wdone, busy, err;

  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  xvc_mm_axil_bridge #(
    .AXI_ADDR_WIDTH(32),
    .BASE_ADDR     (Base)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .opcode        (opcode),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .wdone         (wdone),
    .busy          (busy),
    .m_axil_awaddr (m_awaddr),
    .m_axil_awprot (m_awprot),
    .m_axil_awvalid(m_awvalid),
    .m_axil_awready(s_awready),
    .m_axil_wdata  (m_wdata),
    .m_axil_wstrb  (m_wstrb),
    .m_axil_wvalid (m_wvalid),
    .m_axil_wready (s_wready),
    .m_axil_bresp  (s_bresp),
    .m_axil_bvalid (s_bvalid),
    .m_axil_bready (m_bready),
    .m_axil_araddr (m_araddr),
    .m_axil_arprot (m_arprot),
    .m_axil_arvalid(m_arvalid),
    .m_axil_arready(s_arready),
    .m_axil_rdata  (s_rdata),
    .m_axil_rresp  (s_rresp),
    .m_axil_rvalid (s_rvalid),
    .m_axil_rready (m_rready),
    .err           (err)
  );

  // Second instance with a 12-bit AXI space and a base near the top, to exercise wrap.
  logic [11:0] w_addr;
  logic [31:0] w_wdata_in, w_rdata, w_wdata;
  logic [1:0]  w_opcode;
  logic        w_rvalid, w_wdone, w_busy, w_err;
  logic [11:0] w_awaddr, w_araddr;
  logic [2:0]  w_awprot, w_arprot;
  logic [3:0]  w_wstrb;
  logic        w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;

  xvc_mm_axil_bridge #(
    .AXI_ADDR_WIDTH(12),
    .BASE_ADDR     (12'hF00)
  ) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .addr          (w_addr),
    .wdata         (w_wdata_in),
    .opcode        (w_opcode),
    .rdata         (w_rdata),
    .rvalid        (w_rvalid),
    .wdone         (w_wdone),
    .busy          (w_busy),
    .m_axil_awaddr (w_awaddr),
    .m_axil_awprot (w_awprot),
    .m_axil_awvalid(w_awvalid),
    .m_axil_awready(1'b1),
    .m_axil_wdata  (w_wdata),
    .m_axil_wstrb  (w_wstrb),
    .m_axil_wvalid (w_wvalid),
    .m_axil_wready (1'b1),
    .m_axil_bresp  (2'b00),
    .m_axil_bvalid (1'b1),
    .m_axil_bready (w_bready),
    .m_axil_araddr (w_araddr),
    .m_axil_arprot (w_arprot),
    .m_axil_arvalid(w_arvalid),
    .m_axil_arready(1'b1),
    .m_axil_rdata  (32'h0000_00A5),
    .m_axil_rresp  (2'b00),
    .m_axil_rvalid (1'b1),
    .m_axil_rready (w_rready),
    .err           (w_err)
  );

  // ---------------- slave model with configurable ready delays ----------------
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  bit          cfg_b_block = 1'b0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;

  assign s_awready = m_awvalid && (aw_cnt >= cfg_aw_dly);
  assign s_wready  = m_wvalid  && (w_cnt  >= cfg_w_dly);
  assign s_arready = m_arvalid && (ar_cnt >= cfg_ar_dly);

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= 32'h0;
    end else begin
      aw_cnt <= (m_awvalid && !s_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid  && !s_wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_arvalid && !s_arready) ? ar_cnt + 1 : 0;
      if (m_awvalid && s_awready) aw_got <= 1'b1;
      if (m_wvalid && s_wready)   w_got  <= 1'b1;
      if ((aw_got || (m_awvalid && s_awready)) && (w_got || (m_wvalid && s_wready)) &&
          !s_bvalid && !cfg_b_block) begin
        s_bvalid <= 1'b1;
        s_bresp  <= cfg_bresp;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else if (s_bvalid && m_bready) begin
        s_bvalid <= 1'b0;
      end
      if (m_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= cfg_rdata;
        s_rresp  <= cfg_rresp;
      end else if (s_rvalid && m_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  resp_t       exp_q[$];
  logic [31:0] model_rdata = 32'h0;
  bit          model_err = 1'b0;
  int          n_wr = 0, n_b_exp = 0, aw_hs_cnt = 0, b_hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  // Monitor: compares AXI requests, completion pulses and valid stability at negedge.
  int          busy_cnt = 0;
  bit          p_aw = 0, p_w = 0, p_ar = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw) begin
          chk("awvalid_held", 32'(m_awvalid), 32'd1);
          chk("awaddr_stable", m_awaddr, p_awaddr);
        end
        if (p_w) begin
          chk("wvalid_held", 32'(m_wvalid), 32'd1);
          chk("wdata_stable", m_wdata, p_wdata);
        end
        if (p_ar) begin
          chk("arvalid_held", 32'(m_arvalid), 32'd1);
          chk("araddr_stable", m_araddr, p_araddr);
        end
        if (m_awvalid && s_awready) begin
          aw_hs_cnt++;
          if (exp_aw.size() == 0) flag("aw_handshake");
          else begin
            chk("awaddr", m_awaddr, exp_aw.pop_front());
            chk("awprot", 32'(m_awprot), 32'd0);
          end
        end
        if (m_wvalid && s_wready) begin
          if (exp_w.size() == 0) flag("w_handshake");
          else begin
            chk("wdata", m_wdata, exp_w.pop_front());
            chk("wstrb", 32'(m_wstrb), 32'hF);
          end
        end
        if (m_arvalid && s_arready) begin
          if (exp_ar.size() == 0) flag("ar_handshake");
          else begin
            chk("araddr", m_araddr, exp_ar.pop_front());
            chk("arprot", 32'(m_arprot), 32'd0);
          end
        end
        if (s_bvalid && m_bready) b_hs_cnt++;
        if (wdone && rvalid) flag("double_pulse");
        if (wdone || rvalid) begin
          if (exp_q.size() == 0) flag("completion_pulse");
          else begin
            e = exp_q.pop_front();
            chk("pulse_kind_rd", 32'(rvalid), 32'(e.is_rd));
            chk("rdata", rdata, e.data);
            chk("err", 32'(err), 32'(e.err));
            chk("busy_at_pulse", 32'(busy), 32'd0);
            if (e.busy >= 0) chk("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end else if (busy) begin
          busy_cnt++;
        end
        p_aw = m_awvalid && !s_awready; p_awaddr = m_awaddr;
        p_w  = m_wvalid  && !s_wready;  p_wdata  = m_wdata;
        p_ar = m_arvalid && !s_arready; p_araddr = m_araddr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for 1+hold cycles and record what it must produce.
  task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                       input int hold, input int exp_busy);
    resp_t e;
    if (op == OpWrite) begin
      exp_aw.push_back(Base + 32'(a));
      exp_w.push_back(d);
      n_wr++; n_b_exp++;
      e.is_rd = 1'b0;
      e.data  = model_rdata;
      e.err   = model_err || (cfg_bresp != 2'b00);
    end else begin
      exp_ar.push_back(Base + 32'(a));
      model_rdata = cfg_rdata;
      e.is_rd = 1'b1;
      e.data  = cfg_rdata;
      e.err   = model_err || (cfg_rresp != 2'b00);
    end
    model_err = e.err;
    e.busy    = exp_busy;
    exp_q.push_back(e);
    opcode = op; addr = a; wdata = d;
    repeat (1 + hold) tick();
    opcode = OpWait;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout with %0d responses pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    addr = '0; wdata = '0; opcode = OpWait;
    w_addr = '0; w_wdata_in = '0; w_opcode = OpWait;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({wdone, rvalid}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_wdata", m_wdata, 0);
    rst = 1'b0;
    tick();

    // Zero-wait write: awaddr 0x4010, busy 3 cycles
    issue(OpWrite, 12'h010, 32'h0000_0001, 0, 3);
    wait_idle("write_basic");

    // Zero-wait read
    cfg_rdata = 32'h1234_5678;
    issue(OpRead, 12'h020, 32'h0, 0, 3);
    wait_idle("read_basic");

    // Read with 5-cycle ARREADY delay: busy 3+5
    cfg_ar_dly = 5; cfg_rdata = 32'hA5A5_0001;
    issue(OpRead, 12'h00C, 32'h0, 0, 8);
    wait_idle("read_ar_delay");
    cfg_ar_dly = 0;

    // W accepted 3 cycles before AW: busy 3+3
    cfg_aw_dly = 3;
    issue(OpWrite, 12'h100, 32'hDEAD_BEEF, 0, 6);
    wait_idle("write_w_first");
    cfg_aw_dly = 0;

    // AW before W
    cfg_w_dly = 2;
    issue(OpWrite, 12'h0FC, 32'h0BAD_CAFE, 0, 5);
    wait_idle("write_aw_first");
    cfg_w_dly = 0;

    // Opcode held WRITE two cycles past acceptance: still one AXI write
    issue(OpWrite, 12'h004, 32'h0000_0055, 2, 3);
    wait_idle("write_held_opcode");

    // Reserved opcode and WAIT: nothing happens
    opcode = OpRsvd; addr = 12'h123;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rsvd_busy", 32'(busy), 0);
      chk("rsvd_valids", 32'({m_awvalid, m_arvalid}), 0);
    end
    opcode = OpWait;
    repeat (2) tick();
    chk("wait_busy", 32'(busy), 0);

    // Back-to-back: READ presented during the wdone cycle is accepted
    issue(OpWrite, 12'h008, 32'h0000_00AA, 0, 3);
    k = 0;
    while (!wdone && k < 20) begin
      tick();
      k++;
    end
    chk("b2b_wdone_seen", 32'(wdone), 1);
    cfg_rdata = 32'h0000_0ABC;
    issue(OpRead, 12'h008, 32'h0, 0, 3);
    wait_idle("back_to_back");

    // SLVERR read sets sticky err; later OKAY transactions keep it
    cfg_rresp = 2'b10; cfg_rdata = 32'hCAFE_0002;
    issue(OpRead, 12'h030, 32'h0, 0, 3);
    wait_idle("read_slverr");
    cfg_rresp = 2'b00;
    issue(OpWrite, 12'h034, 32'h0000_0777, 0, 3);
    wait_idle("write_after_err");
    cfg_rdata = 32'h0000_1111;
    issue(OpRead, 12'h038, 32'h0, 0, 3);
    wait_idle("read_after_err");

    // Reset while in WR_RESP abandons the write
    cfg_b_block = 1'b1;
    issue(OpWrite, 12'h040, 32'h0000_0040, 0, -1);
    k = 0;
    while (!m_bready && k < 20) begin
      tick();
      k++;
    end
    chk("wresp_reached", 32'(m_bready), 1);
    rst = 1'b1;
    exp_q.delete();
    n_b_exp--;
    model_err = 1'b0; model_rdata = 32'h0;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wdone", 32'(wdone), 0);
    chk("midrst_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    chk("midrst_err", 32'(err), 0);
    rst = 1'b0; cfg_b_block = 1'b0;
    tick();
    cfg_rdata = 32'h0BAD_F00D;
    issue(OpRead, 12'h050, 32'h0, 0, 3);
    wait_idle("read_after_rst");

    // DECERR write response also sets err
    cfg_bresp = 2'b11;
    issue(OpWrite, 12'h060, 32'h0000_0060, 0, 3);
    wait_idle("write_decerr");
    cfg_bresp = 2'b00;

    // Address wrap on the 12-bit instance: 0xF00 + 0x200 -> 0x100, 0xF00 + 0x180 -> 0x080
    w_opcode = OpWrite; w_addr = 12'h200; w_wdata_in = 32'h0000_1357;
    tick();
    w_opcode = OpWait;
    chk("wrap_awaddr", 32'(w_awaddr), 32'h100);
    chk("wrap_awvalid", 32'(w_awvalid), 1);
    repeat (8) tick();
    w_opcode = OpRead; w_addr = 12'h180;
    tick();
    w_opcode = OpWait;
    chk("wrap_araddr", 32'(w_araddr), 32'h080);
    chk("wrap_arvalid", 32'(w_arvalid), 1);
    repeat (8) tick();
    chk("wrap_rdata", w_rdata, 32'hA5);
    chk("wrap_wdata", w_wdata, 32'h1357);
    chk("wrap_idle", 32'({w_err, w_awprot, w_arprot, w_wvalid, w_bready, w_rready,
                          w_wdone, w_rvalid, w_busy, w_wstrb}), 32'hF);

    // Totals: one AW per write issued, one B per write not abandoned
    chk("aw_handshakes", aw_hs_cnt, n_wr);
    chk("b_handshakes", b_hs_cnt, n_b_exp);
    chk("pending_aw", exp_aw.size(), 0);
    chk("pending_w", exp_w.size(), 0);
    chk("pending_ar", exp_ar.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
